// File: rtl/cocc_pkg.sv
// rtl/cocc_pkg.sv - shared run-state and phase encodings for the CPU core
// Purpose: run-state enum and one-hot phase constants used by run_ctrl,
//          the datapath and the RAM controller.
// Ports:   none (package).
package cocc_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } run_state_e;

  localparam logic [2:0] PH_CYCLE = 3'b001;
  localparam logic [2:0] PH_RAM   = 3'b010;
  localparam logic [2:0] PH_INT   = 3'b100;

  // Phases only rotate in these two states.
  function automatic logic is_active(input run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// rtl/run_ctrl_if.sv - request/status bundle between front panel and run_ctrl
// Purpose: groups the run/halt/step requests, the HLT decode flag and the
//          phase strobes / status outputs of the run controller.
// Ports:   master - drives run_req, halt_req, step_req, hlt_instr; reads status
//          slave  - run_ctrl side: reads requests, drives strobes, halted,
//                   state and cycle_count
interface run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic             hlt_instr;
  logic             cycle_clk;
  logic             ram_clk;
  logic             internal_clk;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output run_req, halt_req, step_req, hlt_instr,
    input  cycle_clk, ram_clk, internal_clk, halted, state, cycle_count
  );

  modport slave (
    input  run_req, halt_req, step_req, hlt_instr,
    output cycle_clk, ram_clk, internal_clk, halted, state, cycle_count
  );
endinterface

// File: rtl/phase_gen.sv
// rtl/phase_gen.sv - one-hot three-phase rotator
// Purpose: holds the current phase (cycle -> RAM -> internal) and rotates it
//          when enabled; a synchronous restart forces it back to the cycle phase.
// Ports:   clk, reset (async active-high)
//          adv_i     - rotate one step on this edge
//          restart_i - load PH_CYCLE on this edge (wins over adv_i)
//          phase_o   - one-hot phase
module phase_gen
  import cocc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       adv_i,
  input  logic       restart_i,
  output logic [2:0] phase_o
);

  logic [2:0] phase_q;
  logic [2:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (restart_i) begin
      phase_d = PH_CYCLE;
    end else if (adv_i) begin
      phase_d = {phase_q[1:0], phase_q[2]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_CYCLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run/halt/single-step controller for the three-phase CPU cycle
// Purpose: holds the core quiescent after reset, then runs, halts at cycle
//          boundaries (halt request or decoded HLT) and single-steps one cycle.
// Ports:   clk, reset (async active-high)
//          bus (run_ctrl_if.slave): run_req/halt_req/step_req pulses, hlt_instr
//          decode flag in; cycle_clk/ram_clk/internal_clk strobes, halted,
//          state and the wrapping retired-cycle counter cycle_count out
module run_ctrl
  import cocc_pkg::*;
#(
  parameter int RESET_HOLD    = 4,
  parameter bit START_RUNNING = 1'b0,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  run_ctrl_if.slave  bus
);

  localparam logic [7:0]  HOLD_LAST  = 8'(RESET_HOLD - 1);
  localparam run_state_e  AFTER_HOLD = START_RUNNING ? ST_RUN : ST_HALTED;

  run_state_e       state_q, state_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;

  logic [2:0]       phase;
  logic             active;
  logic             boundary;
  logic             restart;

  assign active   = is_active(state_q);
  assign boundary = active && (phase == PH_INT);
  // Any edge that leaves the core stopped parks the phase at PH_CYCLE, so
  // the next RUN/STEP entry always begins with cycle_clk.
  assign restart  = !is_active(state_d);

  phase_gen u_phase_gen (
    .clk       (clk),
    .reset     (reset),
    .adv_i     (active),
    .restart_i (restart),
    .phase_o   (phase)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    halt_pend_d = halt_pend_q;
    cnt_d       = cnt_q;

    if (boundary) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = AFTER_HOLD;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        // A halt_req on the boundary clk itself still stops this cycle.
        halt_pend_d = halt_pend_q | bus.halt_req;
        if (boundary && (halt_pend_d || bus.hlt_instr)) begin
          state_d     = ST_HALTED;
          halt_pend_d = 1'b0;
        end
      end
      ST_HALTED: begin
        if (bus.step_req) begin
          state_d = ST_STEP;
        end else if (bus.run_req) begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        if (boundary) begin
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  assign halted_d = (state_d == ST_HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= 8'd0;
      halt_pend_q <= 1'b0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      halt_pend_q <= halt_pend_d;
      cnt_q       <= cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.cycle_clk    = active & phase[0];
  assign bus.ram_clk      = active & phase[1];
  assign bus.internal_clk = active & phase[2];
  assign bus.halted       = halted_q;
  assign bus.state        = state_q;
  assign bus.cycle_count  = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - self-checking bench for run_ctrl
module tb_run_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, hlt_instr = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  run_ctrl_if #(.CNT_W(16)) if0 ();
  run_ctrl_if #(.CNT_W(4))  if1 ();

  assign if0.run_req = run_req;   assign if1.run_req = run_req;
  assign if0.halt_req = halt_req; assign if1.halt_req = halt_req;
  assign if0.step_req = step_req; assign if1.step_req = step_req;
  assign if0.hlt_instr = hlt_instr; assign if1.hlt_instr = hlt_instr;

  run_ctrl #(.RESET_HOLD(4), .START_RUNNING(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  run_ctrl #(.RESET_HOLD(2), .START_RUNNING(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  logic [2:0] str0, str1;
  assign str0 = {if0.internal_clk, if0.ram_clk, if0.cycle_clk};
  assign str1 = {if1.internal_clk, if1.ram_clk, if1.cycle_clk};

  // Behavioural model: mode, clks spent in HOLD, position inside the
  // three-clk cycle (0 cycle, 1 ram, 2 internal), pending halt, cycles done.
  localparam int M_HOLD = 0, M_RUN = 1, M_HALTED = 2, M_STEP = 3;
  int          mode [2];
  int          hold [2];
  int          pos  [2];
  bit          pend [2];
  int unsigned done [2];

  function automatic int hold_len(input int i);   return (i == 0) ? 4 : 2; endfunction
  function automatic int after_hold(input int i); return (i == 0) ? M_HALTED : M_RUN; endfunction
  function automatic int cnt_w(input int i);      return (i == 0) ? 16 : 4; endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_HOLD; hold[i] = 0; pos[i] = 0; pend[i] = 1'b0; done[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      case (mode[i])
        M_HOLD: begin
          hold[i]++;
          if (hold[i] == hold_len(i)) mode[i] = after_hold(i);
        end
        M_RUN: begin
          if (halt_req) pend[i] = 1'b1;
          if (pos[i] == 2) begin
            done[i]++;
            pos[i] = 0;
            if (pend[i] || hlt_instr) begin
              mode[i] = M_HALTED;
              pend[i] = 1'b0;
            end
          end else pos[i]++;
        end
        M_HALTED: begin
          pos[i] = 0;
          if (step_req) mode[i] = M_STEP;
          else if (run_req) mode[i] = M_RUN;
        end
        default: begin
          if (pos[i] == 2) begin
            done[i]++;
            pos[i] = 0;
            mode[i] = M_HALTED;
          end else pos[i]++;
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input logic [2:0] s, input logic h,
                            input logic [1:0] st, input logic [31:0] c);
    logic [2:0]  exp_s;
    logic [31:0] exp_c;
    exp_s = ((mode[i] == M_RUN) || (mode[i] == M_STEP)) ? 3'(1 << pos[i]) : 3'b000;
    exp_c = done[i] & ((32'd1 << cnt_w(i)) - 32'd1);
    chk($sformatf("u%0d.strobes", i), 32'(s), 32'(exp_s));
    chk($sformatf("u%0d.halted", i), 32'(h), 32'(mode[i] == M_HALTED));
    chk($sformatf("u%0d.state", i), 32'(st), 32'(mode[i]));
    chk($sformatf("u%0d.cycle_count", i), c, exp_c);
  endtask

  always @(negedge clk) begin
    check_inst(0, str0, if0.halted, if0.state, 32'(if0.cycle_count));
    check_inst(1, str1, if1.halted, if1.state, 32'(if1.cycle_count));
  end

  initial begin
    model_reset();
    #12 reset = 1'b0;

    // Reset release: u0 holds 4 clks then halts; u1 holds 2 clks then runs.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("u0.hold_state", 32'(if0.state), 0);
      chk("u0.hold_strobes", 32'(str0), 0);
      if (k == 0) chk("u1.hold_state", 32'(if1.state), 0);
      if (k == 1) begin
        chk("u1.run_entry_state", 32'(if1.state), 1);
        chk("u1.run_entry_strobe", 32'(str1), 1);
      end
    end
    @(negedge clk);
    chk("u0.halted_after_hold", 32'(if0.halted), 1);
    chk("u0.count_after_hold", 32'(if0.cycle_count), 0);

    // Free run for five cycles.
    run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("u0.run_rotation", 32'(str0), 32'(1 << (k % 3)));
      @(negedge clk);
    end
    chk("u0.count_5", 32'(if0.cycle_count), 5);

    // halt_req during a ram clk: internal still fires, then halted.
    @(negedge clk);
    chk("u0.ram_before_halt", 32'(str0), 2);
    halt_req = 1'b1;
    @(negedge clk); halt_req = 1'b0;
    chk("u0.internal_after_halt_req", 32'(str0), 4);
    chk("u0.not_yet_halted", 32'(if0.halted), 0);
    @(negedge clk);
    chk("u0.halted_at_boundary", 32'(if0.halted), 1);
    chk("u0.count_6", 32'(if0.cycle_count), 6);

    // step_req and run_req together: step wins; halt_req mid-step ignored.
    step_req = 1'b1; run_req = 1'b1;
    @(negedge clk); step_req = 1'b0; run_req = 1'b0;
    chk("u0.step_state", 32'(if0.state), 3);
    chk("u0.step_cycle", 32'(str0), 1);
    halt_req = 1'b1;
    @(negedge clk); halt_req = 1'b0;
    chk("u0.step_ram", 32'(str0), 2);
    @(negedge clk);
    chk("u0.step_internal", 32'(str0), 4);
    @(negedge clk);
    chk("u0.halted_after_step", 32'(if0.halted), 1);
    chk("u0.count_7", 32'(if0.cycle_count), 7);

    // Run 7 cycles; hlt_instr is high off-internal and only on the last internal.
    @(negedge clk); run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    for (int k = 0; k < 21; k++) begin
      hlt_instr = ((k % 3) != 2) || (k == 20);
      chk("u0.hlt_run_rotation", 32'(str0), 32'(1 << (k % 3)));
      @(negedge clk);
    end
    hlt_instr = 1'b0;
    chk("u0.halted_on_hlt", 32'(if0.halted), 1);
    chk("u0.count_14", 32'(if0.cycle_count), 14);

    // Asynchronous reset in the middle of a ram clk.
    run_req = 1'b1;
    @(negedge clk); run_req = 1'b0;
    @(negedge clk);
    chk("u0.ram_before_reset", 32'(str0), 2);
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("u0.strobes_in_reset", 32'(str0), 0);
    chk("u1.strobes_in_reset", 32'(str1), 0);
    chk("u0.state_in_reset", 32'(if0.state), 0);
    chk("u0.count_in_reset", 32'(if0.cycle_count), 0);
    chk("u1.count_in_reset", 32'(if1.cycle_count), 0);
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("u0.rehold_state", 32'(if0.state), 0);
    chk("u1.rehold_state", 32'(if1.state), 0);
    @(negedge clk);
    chk("u1.rerun_strobe", 32'(str1), 1);
    repeat (51) @(negedge clk);
    chk("u1.count_wrap_1", 32'(if1.cycle_count), 1);
    chk("u1.wrap_cycle_strobe", 32'(str1), 1);

    // Randomized traffic with the occasional asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      run_req   = ($urandom_range(0, 9) == 0);
      halt_req  = ($urandom_range(0, 9) == 0);
      step_req  = ($urandom_range(0, 9) == 0);
      hlt_instr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #3 reset = 1'b1;
        model_reset();
        @(negedge clk); #2 reset = 1'b0;
      end
    end
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; hlt_instr = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Run/halt/single-step controller for the CPU's three-phase cycle.
- Owns the one-hot phase rotation: cycle, then RAM, then internal.
- Emits one phase strobe per clk while the core is active.
- Freezes the phases at a cycle boundary on a halt request or a decoded HLT instruction.
- Sits between the board clock and the CPU datapath, RAM and register file; the debug/front-panel logic drives its requests.

Parameters:
- RESET_HOLD, 4: clk cycles the core is held quiescent after reset deasserts (1..255).
- START_RUNNING, 0: 1 = enter RUN after hold; 0 = enter HALTED.
- CNT_W, 16: width of the retired-cycle counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run_req  in  1  single-clk pulse: resume free running
- halt_req  in  1  single-clk pulse: stop at next cycle boundary
- step_req  in  1  single-clk pulse: execute exactly one full cycle
- hlt_instr  in  1  decoder flag: current instruction is HLT
- cycle_clk  out  1  phase-0 strobe (fetch/cycle)
- ram_clk  out  1  phase-1 strobe (memory access)
- internal_clk  out  1  phase-2 strobe (register writeback)
- halted  out  1  core is stopped and ready for run/step
- state  out  2  HOLD=0, RUN=1, HALTED=2, STEP=3
- cycle_count  out  CNT_W  number of completed 3-phase cycles, wraps

Behaviour:
- Reset (async, active-high):
  - state=HOLD, phase=3'b001, hold counter=0, halt_pend=0, cycle_count=0.
  - All strobes are 0 combinationally while reset is high; halted=0.
- Phase register:
  - One-hot 001→010→100→001.
  - Advances on posedge clk only when active (state RUN or STEP).
  - Otherwise it holds, and is always 001 outside RUN/STEP.
- Strobes:
  - cycle_clk = active & phase[0]; ram_clk = active & phase[1]; internal_clk = active & phase[2].
  - Exactly one strobe is high per active clk.
  - No strobe is ever high in HOLD or HALTED.
- Boundary event: active & phase==100. cycle_count increments by 1 at every boundary, wrapping at 2^CNT_W.
- HOLD:
  - Counts RESET_HOLD clks.
  - On the clk where the count reaches RESET_HOLD-1, goes to RUN if START_RUNNING=1, else HALTED.
  - Requests arriving in HOLD are ignored.
- RUN:
  - halt_req sets halt_pend, whatever the phase.
  - At a boundary, if halt_pend or hlt_instr: go to HALTED, phase→001, clear halt_pend.
  - Otherwise continue.
  - hlt_instr is sampled only on the internal_clk clk.
  - run_req and step_req are ignored.
- HALTED:
  - halted=1.
  - step_req goes to STEP; run_req goes to RUN.
  - If both arrive on the same clk, step_req wins.
  - halt_req is ignored.
  - Entry into RUN/STEP starts with phase 001, so cycle_clk is high on the first clk after the request edge.
- STEP:
  - Runs exactly 3 clks (one full cycle), then goes to HALTED at the boundary.
  - halt_req, run_req, step_req and hlt_instr during STEP are ignored; halt_pend is not set.
- Latency:
  - Request sampled at edge N → first strobe at clk N+1.
  - halt_req in RUN → halted=1 after the current cycle completes: at most 3 clks, at least 1.
- Reset mid-cycle: partial cycle is abandoned; strobes drop immediately; HOLD restarts.
- halted and state are registered outputs; strobes are combinational from registered state and phase.

Decomposition:
- Shared package (cocc_pkg): state encoding constants (ST_HOLD, ST_RUN, ST_HALTED, ST_STEP) and phase one-hot constants (PH_CYCLE=3'b001, PH_RAM=3'b010, PH_INT=3'b100).
- Phase constants are shared with the datapath and RAM controller.
- One sub-module, phase_gen: a one-hot 3-phase rotator with an advance enable and a sync restart to 001.
- run_ctrl keeps the FSM, the hold counter, halt_pend and cycle_count.

Test Plan:
- Reset release, RESET_HOLD=4, START_RUNNING=0:
  - state=0 for 4 clks, then halted=1.
  - No strobe ever high.
  - cycle_count=0.
- From HALTED, pulse run_req at edge 10:
  - Strobes are cycle, ram, internal on clks 11, 12, 13, repeating.
  - After 5 cycles, cycle_count=5.
- In RUN, pulse halt_req on a ram_clk clk:
  - internal_clk still fires on the next clk.
  - Then halted=1, phase=001, cycle_count incremented once more.
- From HALTED, pulse step_req and run_req on the same clk:
  - Exactly 3 strobes (one cycle), then halted=1.
  - cycle_count +1.
  - Also pulse halt_req mid-step: step still completes, and no halt is pending afterwards.
- RUN with hlt_instr=1 held during internal_clk of cycle 7: halts at that boundary; cycle_count=7.
  - Also set CNT_W=4 and run 17 cycles: cycle_count wraps to 1.
- Assert reset asynchronously (not on a clk edge) during ram_clk:
  - All strobes go 0 immediately.
  - state=HOLD, cycle_count=0.
  - HOLD sequence restarts after release.
